// File: rtl/hci_tcdm_responder_pkg.sv
// Shared types and helpers for the HCI TCDM responder bank model.
package hci_tcdm_responder_pkg;

  localparam int MAX_LATENCY = 8;
  // Galois right-shift mask for taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int RESP_DW = 32;

  typedef struct packed {
    logic               valid;
    logic [RESP_DW-1:0] data;
  } resp_stage_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hci_tcdm_resp_delay_line.sv
// LATENCY-deep read response pipe; data only advances with a valid beat so the
// last stage holds the most recent read data between pulses.
module hci_tcdm_resp_delay_line
  import hci_tcdm_responder_pkg::*;
#(
  parameter int  LATENCY = 1,
  parameter type stage_t = resp_stage_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  stage_t in,
  output stage_t out
);

  stage_t stg [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) stg[i] <= '0;
    end else begin
      stg[0].valid <= in.valid;
      if (in.valid) stg[0].data <= in.data;
      for (int i = 1; i < LATENCY; i++) begin
        stg[i].valid <= stg[i-1].valid;
        if (stg[i-1].valid) stg[i].data <= stg[i-1].data;
      end
    end
  end

  assign out = stg[LATENCY-1];

endmodule

// File: rtl/hci_tcdm_responder.sv
// HCI TCDM bank model: same-cycle grant, byte-enabled writes, fixed-latency reads.
// Optional pseudo-random grant stalls when HCI_TCDM_RESP_STALL_EN is defined.
module hci_tcdm_responder
  import hci_tcdm_responder_pkg::*;
#(
  parameter int          DW           = 32,
  parameter int          AW           = 32,
  parameter int          DEPTH        = 1024,
  parameter int          LATENCY      = 1,
  parameter int unsigned STALL_THRESH = 64,
  parameter logic [15:0] STALL_SEED   = 16'hACE1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  output logic            gnt,
  input  logic [AW-1:0]   add,
  input  logic            wen,
  input  logic [DW/8-1:0] be,
  input  logic [DW-1:0]   data,
  output logic [DW-1:0]   r_data,
  output logic            r_valid,
  output logic [31:0]     n_reads,
  output logic [31:0]     n_writes
);

  localparam int OFS = $clog2(DW/8);
  localparam int IW  = $clog2(DEPTH);
  localparam int LAT = (LATENCY > MAX_LATENCY) ? MAX_LATENCY : ((LATENCY < 1) ? 1 : LATENCY);
  localparam logic [7:0] THRESH = 8'(STALL_THRESH);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] data;
  } stage_t;

  logic [DW-1:0] mem [DEPTH];
  logic [IW-1:0] idx;
  logic          hs, rd_hs, wr_hs;
  logic          add_unused;
  stage_t        rd_in, rd_out;

  // upper address bits and byte offset do not select a word
  assign add_unused = ^add;
  assign idx   = add[OFS +: IW];
  assign hs    = req && gnt;
  assign rd_hs = hs && wen;
  assign wr_hs = hs && !wen;

`ifdef HCI_TCDM_RESP_STALL_EN
  logic [15:0] lfsr;
  logic        lfsr_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= STALL_SEED;
    else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0);
  end

  assign lfsr_unused = ^lfsr[15:8];
  assign gnt = req && !(lfsr[7:0] < THRESH);
`else
  logic cfg_unused;
  assign cfg_unused = ^{STALL_SEED, THRESH};
  assign gnt = req;
`endif

  // contents are deliberately not reset
  always_ff @(posedge clk) begin
    for (int b = 0; b < DW/8; b++)
      if (wr_hs && be[b]) mem[idx][8*b +: 8] <= data[8*b +: 8];
  end

  always_comb begin
    rd_in       = '0;
    rd_in.valid = rd_hs;
    rd_in.data  = mem[idx];
  end

  hci_tcdm_resp_delay_line #(
    .LATENCY (LAT),
    .stage_t (stage_t)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (rd_in),
    .out   (rd_out)
  );

  assign r_valid = rd_out.valid;
  assign r_data  = rd_out.data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_reads  <= '0;
      n_writes <= '0;
    end else begin
      if (rd_hs) n_reads  <= sat_inc(n_reads);
      if (wr_hs) n_writes <= sat_inc(n_writes);
    end
  end

endmodule

// File: tb/tb_hci_tcdm_responder.sv
// Randomized + directed bench for hci_tcdm_responder against a queue-based bank model.
module tb_hci_tcdm_responder;

  localparam int          DW     = 32;
  localparam int          AW     = 32;
  localparam int          DEPTH  = 1024;
  localparam int          LAT    = 3;
  localparam int unsigned THRESH = 64;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req = 1'b0, wen = 1'b0;
  logic [AW-1:0] add = '0;
  logic [3:0]    be = '0;
  logic [31:0]   data = '0;
  logic          gnt, r_valid;
  logic [31:0]   r_data, n_reads, n_writes;

  always #5 clk = ~clk;

  hci_tcdm_responder #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .LATENCY(LAT),
    .STALL_THRESH(THRESH), .STALL_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .add(add), .wen(wen),
    .be(be), .data(data), .r_data(r_data), .r_valid(r_valid),
    .n_reads(n_reads), .n_writes(n_writes)
  );

  int n_tests = 0, n_fail = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural bank model ----------------
  typedef struct { int unsigned due; logic [31:0] d; } rd_t;
  rd_t         q[$];
  logic [31:0] mm [DEPTH];
  int unsigned cyc = 0;
  logic        e_valid = 1'b0;
  logic [31:0] e_rdata = '0, e_nr = '0, e_nw = '0;
  logic [9:0]  widx;

`ifdef HCI_TCDM_RESP_STALL_EN
  logic [15:0] m_lfsr = SEED;
  function automatic bit exp_gnt();
    return req && (int'(m_lfsr[7:0]) >= int'(THRESH));
  endfunction
`else
  function automatic bit exp_gnt();
    return req;
  endfunction
`endif

  // A read handshake on edge n is visible after edge n+LAT-1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      e_valid = 1'b0;
      e_rdata = '0;
      e_nr    = '0;
      e_nw    = '0;
`ifdef HCI_TCDM_RESP_STALL_EN
      m_lfsr  = SEED;
`endif
    end else begin
      cyc++;
      if (exp_gnt()) begin
        widx = add[2 +: 10];
        if (wen) begin
          q.push_back('{cyc + LAT - 1, mm[widx]});
          if (e_nr != 32'hFFFF_FFFF) e_nr++;
        end else begin
          for (int b = 0; b < 4; b++)
            if (be[b]) mm[widx][8*b +: 8] = data[8*b +: 8];
          if (e_nw != 32'hFFFF_FFFF) e_nw++;
        end
      end
`ifdef HCI_TCDM_RESP_STALL_EN
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
`endif
      if (q.size() > 0 && q[0].due == cyc) begin
        e_valid = 1'b1;
        e_rdata = q[0].d;
        void'(q.pop_front());
      end else begin
        e_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("gnt",      {31'b0, gnt},     {31'b0, exp_gnt()});
      chk("r_valid",  {31'b0, r_valid}, {31'b0, e_valid});
      chk("r_data",   r_data,   e_rdata);
      chk("n_reads",  n_reads,  e_nr);
      chk("n_writes", n_writes, e_nw);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Returns one time step after the handshake edge.
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    bit ok = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; wen = w; add = a; be = b; data = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (gnt) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL issue_gnt_timeout: got no grant, expected grant within 200 cycles");
    end
    @(posedge clk); #1;
    req = 1'b0; wen = 1'b0; be = '0;
  endtask

  task automatic expect_read(input logic [31:0] exp, input string name);
    bit got = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (r_valid) begin
        chk({name, "_lat"}, k, LAT);
        chk({name, "_data"}, r_data, exp);
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL %s_timeout: got no r_valid, expected one within 20 cycles", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b2b [3];
    int pulses;
    b2b[0] = 32'hC0FF_EE00; b2b[1] = 32'h4444_4444; b2b[2] = 32'h8888_8888;

    repeat (3) @(posedge clk);
    #1 checking = 1'b1;
    @(negedge clk);
    chk("rst_r_valid",  {31'b0, r_valid}, 32'h0);
    chk("rst_r_data",   r_data,   32'h0);
    chk("rst_n_reads",  n_reads,  32'h0);
    chk("rst_n_writes", n_writes, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    issue(1'b0, 32'h10, 4'hF, 32'hDEAD_BEEF);
    issue(1'b1, 32'h10, 4'h0, 32'h0);
    expect_read(32'hDEAD_BEEF, "rd_deadbeef");
    chk("cnt_writes_1", n_writes, 32'd1);
    chk("cnt_reads_1",  n_reads,  32'd1);

    issue(1'b0, 32'h20, 4'hF,    32'h1111_1111);
    issue(1'b0, 32'h20, 4'b0101, 32'hAAAA_AAAA);
    issue(1'b1, 32'h20, 4'hF,    32'h0);
    expect_read(32'h11AA_11AA, "rd_byte_en");

    issue(1'b0, 32'h1000, 4'hF, 32'hC0FF_EE00);
    issue(1'b1, 32'h0,    4'h0, 32'h0);
    expect_read(32'hC0FF_EE00, "rd_wrap");

    issue(1'b0, 32'h4, 4'hF, 32'h4444_4444);
    issue(1'b0, 32'h8, 4'hF, 32'h8888_8888);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 req = 1'b1; wen = 1'b1; add = 32'(i * 4);
    end
    @(posedge clk); #1 req = 1'b0; wen = 1'b0;
    repeat (LAT - 3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("b2b_valid", {31'b0, r_valid}, 32'h1);
      chk("b2b_data",  r_data, b2b[i]);
    end
    @(negedge clk);
    chk("b2b_after", {31'b0, r_valid}, 32'h0);

    // reset while a read is in flight
    issue(1'b1, 32'h10, 4'h0, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (r_valid) pulses++;
    end
    chk("rst_flush_pulses", pulses, 0);
    chk("rst_flush_reads",  n_reads,  32'h0);
    chk("rst_flush_writes", n_writes, 32'h0);
    issue(1'b1, 32'h10, 4'h0, 32'h0);
    expect_read(32'hDEAD_BEEF, "mem_retained");

    for (int i = 0; i < 16; i++) issue(1'b0, 32'(i * 4), 4'hF, $urandom);

    repeat (3000) begin
      @(posedge clk); #1;
      req  = ($urandom_range(0, 3) != 0);
      wen  = $urandom_range(0, 1);
      add  = ($urandom << 12) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      be   = 4'($urandom);
      data = $urandom;
    end
    @(posedge clk); #1 req = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
